// File: rtl/nanomamba_weight_loader.sv
// Weight SRAM write front end: unpacks a 32-bit AXI4-Stream of INT8 weights into byte writes.
// Optional checksum check against a host-supplied sum is enabled with NANOMAMBA_WLOAD_CHECKSUM_EN.
module nanomamba_weight_loader #(
    parameter int DEPTH  = 4736,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              error,
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
    output logic [1:0]        err_code,
    input  logic [15:0]       exp_sum,
    output logic [15:0]       chk_sum
`else
    output logic [1:0]        err_code
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, UNPACK, FIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur_addr, cur_addr_n;
    logic [CNT_W-1:0]  remaining, remaining_n;
    logic [CNT_W-1:0]  rem_left;
    logic [31:0]       word, word_n;
    logic [1:0]        idx, idx_n;
    logic              busy_n, done_n, error_n;
    logic [1:0]        err_code_n;
    logic [DATA_W-1:0] cur_byte;
    logic              ovf;
    logic              accept;
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
    logic [15:0]       exp_sum_q, exp_sum_n, chk_sum_n;
`endif

    // Handshake: a word transfers on any rising edge where s_axis_tvalid and s_axis_tready
    // are both high; tready depends only on registered state, never on tvalid.
    assign cur_byte      = DATA_W'(word >> {idx, 3'b000});
    assign ovf           = (cur_addr >= ADDR_W'(DEPTH));
    assign s_axis_tready = (state == WAIT_WORD) ||
                           ((state == UNPACK) && (idx == 2'd3) && (remaining > CNT_W'(1)) && !ovf);
    assign accept        = s_axis_tvalid && s_axis_tready;
    // Bytes still owed once the byte in flight this cycle (if any) has been written.
    assign rem_left      = (state == UNPACK) ? remaining - CNT_W'(1) : remaining;

    assign wr_en   = (state == UNPACK) && !ovf;
    assign wr_addr = (state == UNPACK) ? cur_addr : '0;
    assign wr_data = (state == UNPACK) ? cur_byte : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            word      <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'b00;
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
            exp_sum_q <= '0;
            chk_sum   <= '0;
`endif
        end else begin
            state     <= state_n;
            cur_addr  <= cur_addr_n;
            remaining <= remaining_n;
            word      <= word_n;
            idx       <= idx_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
            err_code  <= err_code_n;
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
            exp_sum_q <= exp_sum_n;
            chk_sum   <= chk_sum_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cur_addr_n  = cur_addr;
        remaining_n = remaining;
        word_n      = word;
        idx_n       = idx;
        busy_n      = busy;
        done_n      = 1'b0;
        error_n     = 1'b0;
        err_code_n  = 2'b00;
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
        exp_sum_n   = exp_sum_q;
        chk_sum_n   = chk_sum;
`endif
        case (state)
            IDLE: begin
                if (start) begin
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
                    exp_sum_n = exp_sum;
                    chk_sum_n = '0;
`endif
                    if (byte_count != '0) begin
                        cur_addr_n  = base_addr;
                        remaining_n = byte_count;
                        busy_n      = 1'b1;
                        state_n     = WAIT_WORD;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            WAIT_WORD: ;
            UNPACK: begin
                if (ovf) begin
                    error_n    = 1'b1;
                    err_code_n = 2'b11;
                    busy_n     = 1'b0;
                    state_n    = IDLE;
                end else begin
                    cur_addr_n  = cur_addr + ADDR_W'(1);
                    remaining_n = remaining - CNT_W'(1);
                    idx_n       = idx + 2'd1;
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
                    chk_sum_n   = chk_sum + 16'(cur_byte);
`endif
                    if (remaining == CNT_W'(1)) begin
                        busy_n  = 1'b0;
                        state_n = FIN;
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
                        if (chk_sum_n != exp_sum_q) begin
                            error_n    = 1'b1;
                            err_code_n = 2'b00;
                        end else begin
                            done_n = 1'b1;
                        end
`else
                        done_n = 1'b1;
`endif
                    end else if (idx == 2'd3) begin
                        state_n = WAIT_WORD;
                    end
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // tlast is judged against the bytes still owed at the moment the word is taken.
        if (accept) begin
            if (s_axis_tlast && (rem_left > CNT_W'(4))) begin
                error_n    = 1'b1;
                err_code_n = 2'b01;
                busy_n     = 1'b0;
                state_n    = IDLE;
            end else if (!s_axis_tlast && (rem_left <= CNT_W'(4))) begin
                error_n    = 1'b1;
                err_code_n = 2'b10;
                busy_n     = 1'b0;
                state_n    = IDLE;
            end else begin
                word_n  = s_axis_tdata;
                idx_n   = 2'd0;
                state_n = UNPACK;
            end
        end
    end

endmodule

// File: tb/tb_nanomamba_weight_loader.sv
// Scoreboard bench for nanomamba_weight_loader: directed loads push expected writes/done/error
// events into a queue that a negedge monitor pops as the DUT produces them.
module tb_nanomamba_weight_loader;
    localparam int W = 23;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] base_addr;
    logic [12:0] byte_count;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] exp_sum;
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
    logic [15:0] chk_sum;
`endif

    always #5 clk = ~clk;

    nanomamba_weight_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_count(byte_count),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .done(done), .error(error),
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
        .err_code(err_code), .exp_sum(exp_sum), .chk_sum(chk_sum)
`else
        .err_code(err_code)
`endif
    );

    // Event encoding: {kind, addr, data}; kind 0 = write, 1 = done, 2 = error (code in data).
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int run = 0;
    int max_run = 0;
    bit wrote = 1'b0;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [W-1:0] got);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected event got=%h exp=none", name, got);
        end else begin
            e = exp_q.pop_front();
            check_val(name, 32'(got), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (wr_en) begin
                run++;
                if (run > max_run) max_run = run;
                sb_pop("write", {2'd0, wr_addr, wr_data});
                last_wr_cyc = cyc;
                wrote = 1'b1;
            end else begin
                run = 0;
            end
            if (done) begin
                sb_pop("done", {2'd1, 21'd0});
                check_val("done_busy_low", 32'(busy), 32'd0);
                if (wrote) check_val("done_gap", 32'(cyc - last_wr_cyc), 32'd1);
                wrote = 1'b0;
            end
            if (error) begin
                sb_pop("error", {2'd2, 19'd0, err_code});
                check_val("error_busy_low", 32'(busy), 32'd0);
                wrote = 1'b0;
            end
        end else begin
            run = 0;
            wrote = 1'b0;
        end
    end

    task automatic exp_bytes(input logic [12:0] base, input int n, input logic [63:0] bytes);
        for (int i = 0; i < n; i++) exp_q.push_back({2'd0, base + 13'(i), bytes[8*i +: 8]});
    endtask

    task automatic exp_done();
        exp_q.push_back({2'd1, 21'd0});
    endtask

    task automatic exp_err(input logic [1:0] c);
        exp_q.push_back({2'd2, 19'd0, c});
    endtask

    task automatic start_load(input logic [12:0] b, input logic [12:0] c, input logic [15:0] s);
        @(negedge clk);
        base_addr = b;
        byte_count = c;
        exp_sum = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        bit hs = 1'b0;
        s_axis_tdata = d;
        s_axis_tlast = last;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            hs = s_axis_tready;
            @(negedge clk);
        end
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL push_word timeout got=no_tready exp=tready word=%h", d);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout got=busy exp=idle");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        byte_count = '0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        exp_sum = '0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  32'({s_axis_tready, wr_en, busy, done, error, err_code, wr_addr, wr_data}), 32'd0);
        rst = 1'b0;

        // Two full words, sustained stream.
        max_run = 0;
        exp_bytes(13'h0400, 8, 64'h8877665544332211);
        exp_done();
        start_load(13'h0400, 13'd8, 16'h0264);
        push_word(32'h44332211, 1'b0);
        push_word(32'h88776655, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_idle();
        check_val("run_len_8", 32'(max_run), 32'd8);

        // Partial final word: upper two bytes discarded.
        exp_bytes(13'h0010, 6, 64'h0000FF11DDCCBBAA);
        exp_done();
        start_load(13'h0010, 13'd6, 16'h041E);
        push_word(32'hDDCCBBAA, 1'b0);
        push_word(32'h0000FF11, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_idle();

        // Early tlast on word 2 of 3.
        exp_bytes(13'h0020, 4, 64'h00000000A4A3A2A1);
        exp_err(2'b01);
        start_load(13'h0020, 13'd12, 16'h0000);
        push_word(32'hA4A3A2A1, 1'b0);
        push_word(32'hB4B3B2B1, 1'b1);
        check_val("tready_after_err", 32'(s_axis_tready), 32'd0);
        s_axis_tvalid = 1'b0;
        wait_idle();

        // Address overflow at the top of the SRAM.
        exp_bytes(13'h127E, 2, 64'h0000000000000201);
        exp_err(2'b11);
        start_load(13'h127E, 13'd4, 16'h0000);
        push_word(32'h04030201, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_idle();

        // Missing tlast on the word carrying the final byte.
        exp_err(2'b10);
        start_load(13'h0030, 13'd3, 16'h0000);
        push_word(32'h00C3C2C1, 1'b0);
        s_axis_tvalid = 1'b0;
        wait_idle();

        // Three words with tvalid held high throughout.
        max_run = 0;
        exp_bytes(13'h0100, 4, 64'h01010101);
        exp_bytes(13'h0104, 4, 64'h02020202);
        exp_bytes(13'h0108, 4, 64'h03030303);
        exp_done();
        start_load(13'h0100, 13'd12, 16'h0018);
        push_word(32'h01010101, 1'b0);
        push_word(32'h02020202, 1'b0);
        push_word(32'h03030303, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_idle();
        check_val("run_len_12", 32'(max_run), 32'd12);

        // A second start while busy must not disturb the load.
        exp_bytes(13'h0200, 4, 64'h10101010);
        exp_bytes(13'h0204, 4, 64'h20202020);
        exp_done();
        start_load(13'h0200, 13'd8, 16'h00C0);
        push_word(32'h10101010, 1'b0);
        s_axis_tvalid = 1'b0;
        start_load(13'h0300, 13'd4, 16'h0000);
        check_val("busy_after_ignored_start", 32'(busy), 32'd1);
        push_word(32'h20202020, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_idle();

        // Zero-length load completes immediately.
        exp_done();
        start_load(13'h0050, 13'd0, 16'h0000);
        wait_idle();

        // Reset in the middle of a word.
        exp_bytes(13'h0300, 2, 64'h0000000000002211);
        start_load(13'h0300, 13'd8, 16'h0000);
        push_word(32'h44332211, 1'b0);
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_val("rst_midload_outputs",
                     32'({s_axis_tready, wr_en, busy, done, error, err_code, wr_addr, wr_data}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
        exp_bytes(13'h0060, 4, 64'h04030201);
        exp_done();
        start_load(13'h0060, 13'd4, 16'h000A);
        push_word(32'h04030201, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_idle();
        check_val("chk_sum_hold", 32'(chk_sum), 32'h000A);

        exp_bytes(13'h0070, 4, 64'h04030201);
        exp_err(2'b00);
        start_load(13'h0070, 13'd4, 16'h000B);
        push_word(32'h04030201, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_idle();
`endif

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
